// File: rtl/led_scanner.sv
// led_scanner: one-hot LED scanner with programmable step period, bounce/wrap/hold modes and preload
module led_scanner #(
    parameter int N_LEDS = 26,
    parameter int DIV_W  = 24,
    parameter int POS_W  = $clog2(N_LEDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [DIV_W-1:0]  period,
    input  logic              load,
    input  logic [POS_W-1:0]  load_pos,
    output logic [N_LEDS-1:0] leds,
    output logic              dir,
    output logic              tick,
    output logic              endpoint
);
    localparam logic [1:0] BOUNCE     = 2'b00;
    localparam logic [1:0] WRAP_LEFT  = 2'b01;
    localparam logic [1:0] WRAP_RIGHT = 2'b10;
    localparam logic [1:0] HOLD       = 2'b11;
    localparam logic [POS_W-1:0] LAST = POS_W'(N_LEDS - 1);

    logic [DIV_W-1:0] cnt;
    logic [POS_W-1:0] pos, nxt_pos, load_clamped;
    logic             nxt_dir, nxt_edge, active, step, go_left, at_top, at_bot, bounce;

    assign active       = en && mode != HOLD;
    assign step         = cnt >= period;
    assign bounce       = mode == BOUNCE;
    assign at_top       = pos == LAST;
    assign at_bot       = pos == '0;
    assign load_clamped = load_pos > LAST ? LAST : load_pos;
    assign leds         = N_LEDS'(1) << pos;

    // Next position/direction for a step, resolving turnaround and wrap at the chain ends
    always_comb begin
        go_left  = mode == WRAP_LEFT || (bounce && !dir);
        nxt_edge = go_left ? at_top : at_bot;
        nxt_pos  = go_left ? (at_top ? (bounce ? LAST - 1'b1 : '0) : pos + 1'b1)
                           : (at_bot ? (bounce ? POS_W'(1) : LAST) : pos - 1'b1);
        nxt_dir  = go_left ? (bounce && at_top) : !(bounce && at_bot);
    end

    // Prescaler, position and status pulses; load overrides any step on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            pos      <= '0;
            dir      <= 1'b0;
            tick     <= 1'b0;
            endpoint <= 1'b0;
        end else if (load) begin
            pos      <= load_clamped;
            cnt      <= '0;
            tick     <= 1'b0;
            endpoint <= 1'b0;
        end else if (active) begin
            cnt      <= step ? '0 : cnt + 1'b1;
            tick     <= step;
            endpoint <= step && nxt_edge;
            if (step) begin
                pos <= nxt_pos;
                dir <= nxt_dir;
            end
        end else begin
            tick     <= 1'b0;
            endpoint <= 1'b0;
        end
    end
endmodule

// File: tb/tb_led_scanner.sv
// tb_led_scanner: directed-vector bench for led_scanner with N_LEDS=4
module tb_led_scanner;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [7:0] period = 8'd0;
    logic       load = 1'b0;
    logic [1:0] load_pos = 2'd0;
    logic [3:0] leds;
    logic       dir, tick, endpoint;
    int n_tests = 0;
    int n_fail = 0;

    led_scanner #(.N_LEDS(4), .DIV_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .period(period),
        .load(load), .load_pos(load_pos), .leds(leds), .dir(dir),
        .tick(tick), .endpoint(endpoint)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [3:0] b_leds[7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    logic       b_edge[7] = '{0, 0, 0, 1, 0, 0, 1};
    logic       b_dir[7]  = '{0, 0, 0, 1, 1, 1, 0};
    logic [3:0] p_leds[8] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000};
    logic       p_tick[8] = '{0, 0, 0, 1, 0, 0, 0, 1};

    initial begin
        #2;
        check("rst_leds", leds, 4'b0001);
        check("rst_dir", dir, 0);
        check("rst_tick", tick, 0);
        check("rst_edge", endpoint, 0);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cyc(1);
            check($sformatf("bounce_leds%0d", i), leds, b_leds[i]);
            check($sformatf("bounce_tick%0d", i), tick, 1);
            check($sformatf("bounce_edge%0d", i), endpoint, b_edge[i]);
            check($sformatf("bounce_dir%0d", i), dir, b_dir[i]);
        end
        period = 8'd3;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            check($sformatf("p3_leds%0d", i), leds, p_leds[i]);
            check($sformatf("p3_tick%0d", i), tick, p_tick[i]);
        end
        period = 8'd0;
        mode = 2'b01;
        cyc(1);
        check("wl_leds", leds, 4'b0001);
        check("wl_edge", endpoint, 1);
        check("wl_dir", dir, 0);
        mode = 2'b10;
        cyc(1);
        check("wr_leds", leds, 4'b1000);
        check("wr_edge", endpoint, 1);
        check("wr_dir", dir, 1);
        en = 1'b0;
        load = 1'b1;
        load_pos = 2'd2;
        cyc(1);
        check("load_leds", leds, 4'b0100);
        check("load_tick", tick, 0);
        load_pos = 2'(7);
        cyc(1);
        check("load_clamp", leds, 4'b1000);
        en = 1'b1;
        load_pos = 2'd1;
        cyc(1);
        check("load_step_leds", leds, 4'b0010);
        check("load_step_tick", tick, 0);
        check("load_step_edge", endpoint, 0);
        check("load_step_dir", dir, 1);
        load = 1'b0;
        mode = 2'b00;
        period = 8'd3;
        cyc(2);
        check("pre_freeze_leds", leds, 4'b0010);
        en = 1'b0;
        cyc(10);
        check("freeze_leds", leds, 4'b0010);
        check("freeze_dir", dir, 1);
        check("freeze_tick", tick, 0);
        en = 1'b1;
        cyc(1);
        check("resume1_leds", leds, 4'b0010);
        check("resume1_tick", tick, 0);
        cyc(1);
        check("resume2_leds", leds, 4'b0001);
        check("resume2_tick", tick, 1);
        mode = 2'b11;
        cyc(10);
        check("hold_leds", leds, 4'b0001);
        check("hold_tick", tick, 0);
        check("hold_dir", dir, 1);
        mode = 2'b00;
        cyc(3);
        check("unhold3_leds", leds, 4'b0001);
        check("unhold3_tick", tick, 0);
        cyc(1);
        check("unhold4_leds", leds, 4'b0010);
        check("unhold4_tick", tick, 1);
        check("unhold4_edge", endpoint, 1);
        check("unhold4_dir", dir, 0);
        period = 8'd0;
        cyc(2);
        check("pre_rst_leds", leds, 4'b1000);
        check("pre_rst_tick", tick, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_leds", leds, 4'b0001);
        check("arst_dir", dir, 0);
        check("arst_tick", tick, 0);
        check("arst_edge", endpoint, 0);
        rst = 1'b0;
        period = 8'd3;
        cyc(3);
        check("post_rst3_leds", leds, 4'b0001);
        check("post_rst3_tick", tick, 0);
        cyc(1);
        check("post_rst4_leds", leds, 4'b0010);
        check("post_rst4_tick", tick, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
